// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory stage: load/store size encoding,
// memory-handshake FSM states and the store-data lane replication helper.
package pipTypes;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } ls_size_t;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_RDWAIT = 1'b1
    } mem_state_t;

    // Copy the low bytes of store data into every lane the access may touch.
    function automatic logic [31:0] replicate_store(input logic [31:0] d, input ls_size_t size);
        case (size)
            LS_BYTE: replicate_store = {4{d[7:0]}};
            LS_HALF: replicate_store = {2{d[15:0]}};
            default: replicate_store = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Little-endian lane logic: selects and extends load data and produces the
// byte-lane enables that stores share. Low address bits illegal for the size are ignored.
module load_align
    import pipTypes::*;
(
    input  logic [31:0] rd_data,
    input  logic [1:0]  addr,
    input  ls_size_t    size,
    input  logic        is_unsigned,
    output logic [31:0] data_out,
    output logic [3:0]  byte_en
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rd_data[{addr, 3'b000} +: 8];
    assign lane_h = addr[1] ? rd_data[31:16] : rd_data[15:0];

    always_comb begin
        data_out = '0;
        byte_en  = '0;
        case (size)
            LS_BYTE: begin
                data_out = {{24{~is_unsigned & lane_b[7]}}, lane_b};
                byte_en  = 4'b0001 << addr;
            end
            LS_HALF: begin
                data_out = {{16{~is_unsigned & lane_h[15]}}, lane_h};
                byte_en  = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data_out = rd_data;
                byte_en  = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory load/store handshake,
// load alignment and MEM/WB register. Optional macro MEM_ALIGN_EXC_EN adds misalignment detection.
module mem_stage
    import pipTypes::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_result,
    input  logic [31:0]           ex_result_2,
    input  logic [4:0]            ex_dest_reg,
    input  logic                  ex_dest_reg_valid,
    input  logic                  ex_inval_dest_reg,
    input  logic                  ex_load_inst,
    input  logic                  ex_store_inst,
    input  logic [1:0]            ex_ls_size,
    input  logic                  ex_ls_unsigned,
    output logic                  stall,
    output logic                  exmem_valid,
    output logic [31:0]           exmem_result,
    output logic [4:0]            exmem_dest_reg,
    output logic                  exmem_dest_reg_valid,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wr_data,
    output logic [3:0]            dmem_byte_en,
    output logic                  dmem_rd,
    output logic                  dmem_wr,
    input  logic                  dmem_waitrequest,
    input  logic [31:0]           dmem_rd_data,
    input  logic                  dmem_rd_valid,
    output logic                  wb_valid,
    output logic [31:0]           wb_result,
    output logic [4:0]            wb_dest_reg,
`ifdef MEM_ALIGN_EXC_EN
    output logic                  addr_err,
`endif
    output logic                  wb_dest_reg_valid
);

    logic        exmem_valid_q, exmem_valid_d;
    logic [31:0] exmem_result_q, exmem_result_d;
    logic [31:0] exmem_result_2_q, exmem_result_2_d;
    logic [4:0]  exmem_dest_reg_q, exmem_dest_reg_d;
    logic        exmem_dv_q, exmem_dv_d;
    logic        exmem_load_q, exmem_load_d;
    logic        exmem_store_q, exmem_store_d;
    ls_size_t    exmem_size_q, exmem_size_d;
    logic        exmem_unsigned_q, exmem_unsigned_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic [4:0]  wb_dest_reg_q, wb_dest_reg_d;
    logic        wb_dv_q, wb_dv_d;

    mem_state_t  state_q, state_d;

    logic        is_store, is_load, misalign, memop, done;
    logic [31:0] load_data;

    assign is_store = exmem_valid_q & exmem_store_q;
    assign is_load  = exmem_valid_q & exmem_load_q & ~exmem_store_q;

`ifdef MEM_ALIGN_EXC_EN
    logic addr_err_q, addr_err_d;

    assign misalign = exmem_valid_q & (exmem_load_q | exmem_store_q) &
                      (((exmem_size_q == LS_HALF) & exmem_result_q[0]) |
                       ((exmem_size_q == LS_WORD) & (exmem_result_q[1:0] != 2'b00)));
    assign addr_err_d = stall ? 1'b0 : misalign;
    assign addr_err   = addr_err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) addr_err_q <= 1'b0;
        else          addr_err_q <= addr_err_d;
    end
`else
    assign misalign = 1'b0;
`endif

    assign memop = (is_store | is_load) & ~misalign;

    load_align u_load_align (
        .rd_data     (dmem_rd_data),
        .addr        (exmem_result_q[1:0]),
        .size        (exmem_size_q),
        .is_unsigned (exmem_unsigned_q),
        .data_out    (load_data),
        .byte_en     (dmem_byte_en)
    );

    assign dmem_addr    = {exmem_result_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_wr_data = replicate_store(exmem_result_2_q, exmem_size_q);

    // Requests are driven straight from the held EX/MEM contents, so they stay stable under waitrequest.
    always_comb begin
        state_d = state_q;
        dmem_rd = 1'b0;
        dmem_wr = 1'b0;
        done    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (memop) begin
                    if (is_store) begin
                        dmem_wr = 1'b1;
                        done    = ~dmem_waitrequest;
                    end else begin
                        dmem_rd = 1'b1;
                        if (!dmem_waitrequest) state_d = MEM_RDWAIT;
                    end
                end
            end
            MEM_RDWAIT: begin
                if (dmem_rd_valid) begin
                    done    = 1'b1;
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    assign stall = memop & ~done;

    always_comb begin
        exmem_valid_d    = exmem_valid_q;
        exmem_result_d   = exmem_result_q;
        exmem_result_2_d = exmem_result_2_q;
        exmem_dest_reg_d = exmem_dest_reg_q;
        exmem_dv_d       = exmem_dv_q;
        exmem_load_d     = exmem_load_q;
        exmem_store_d    = exmem_store_q;
        exmem_size_d     = exmem_size_q;
        exmem_unsigned_d = exmem_unsigned_q;
        wb_valid_d       = 1'b0;
        wb_result_d      = wb_result_q;
        wb_dest_reg_d    = wb_dest_reg_q;
        wb_dv_d          = 1'b0;
        if (!stall) begin
            exmem_valid_d    = ex_valid;
            exmem_result_d   = ex_result;
            exmem_result_2_d = ex_result_2;
            exmem_dest_reg_d = ex_dest_reg;
            exmem_dv_d       = ex_dest_reg_valid & ~ex_inval_dest_reg;
            exmem_load_d     = ex_load_inst;
            exmem_store_d    = ex_store_inst;
            exmem_size_d     = ls_size_t'(ex_ls_size);
            exmem_unsigned_d = ex_ls_unsigned;
            wb_valid_d       = exmem_valid_q;
            wb_result_d      = is_load ? load_data : exmem_result_q;
            wb_dest_reg_d    = exmem_dest_reg_q;
            wb_dv_d          = exmem_dv_q & exmem_valid_q & ~(is_load & misalign);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= MEM_IDLE;
            exmem_valid_q    <= 1'b0;
            exmem_result_q   <= '0;
            exmem_result_2_q <= '0;
            exmem_dest_reg_q <= '0;
            exmem_dv_q       <= 1'b0;
            exmem_load_q     <= 1'b0;
            exmem_store_q    <= 1'b0;
            exmem_size_q     <= LS_BYTE;
            exmem_unsigned_q <= 1'b0;
            wb_valid_q       <= 1'b0;
            wb_result_q      <= '0;
            wb_dest_reg_q    <= '0;
            wb_dv_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            exmem_valid_q    <= exmem_valid_d;
            exmem_result_q   <= exmem_result_d;
            exmem_result_2_q <= exmem_result_2_d;
            exmem_dest_reg_q <= exmem_dest_reg_d;
            exmem_dv_q       <= exmem_dv_d;
            exmem_load_q     <= exmem_load_d;
            exmem_store_q    <= exmem_store_d;
            exmem_size_q     <= exmem_size_d;
            exmem_unsigned_q <= exmem_unsigned_d;
            wb_valid_q       <= wb_valid_d;
            wb_result_q      <= wb_result_d;
            wb_dest_reg_q    <= wb_dest_reg_d;
            wb_dv_q          <= wb_dv_d;
        end
    end

    assign exmem_valid          = exmem_valid_q;
    assign exmem_result         = exmem_result_q;
    assign exmem_dest_reg       = exmem_dest_reg_q;
    assign exmem_dest_reg_valid = exmem_dv_q;
    assign wb_valid             = wb_valid_q;
    assign wb_result            = wb_result_q;
    assign wb_dest_reg          = wb_dest_reg_q;
    assign wb_dest_reg_valid    = wb_dv_q;

endmodule
